// File: rtl/fetch_sequencer.sv
// Dual-issue fetch PC sequencer.
// Chooses the next fetch PC from decode redirects, the branch predictor or
// sequential stride. A redirect taken under a fetch stall is parked in HOLD
// until the stall clears. Every redirect passes through a single FLUSH cycle
// that clears the decode pipeline registers.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FETCH_STRIDE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallf,
  input  logic [1:0]  pcsrcd,
  input  logic [1:0]  pcsrcd2,
  input  logic [31:0] pcbranchd,
  input  logic [31:0] pcbranchd2,
  input  logic [31:0] signextd,
  input  logic [31:0] signextd2,
  input  logic        predict_taken,
  input  logic [31:0] predict_target,
  output logic [31:0] pcf,
  output logic        fetch_valid,
  output logic        flushd,
  output logic        clrbp,
  output logic [15:0] redirect_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_HOLD  = 2'b11
  } state_t;

  localparam logic [31:0] STRIDE_C = 32'(FETCH_STRIDE);

  state_t      state_r;
  logic [31:0] pcf_r;
  logic [31:0] pending_r;
  logic        pending_br_r;
  logic        flush_br_r;
  logic [15:0] redirect_cnt_r;

  logic        redir_s;
  logic        redir_br_s;
  logic [31:0] redir_tgt_s;
  logic [31:0] seq_pc_s;
  logic [15:0] cnt_inc_s;

  // Instruction fetch is word aligned, so every loaded target drops bits [1:0].
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Redirect arbitration: slot-1 jump, slot-1 branch, slot-2 jump, slot-2 branch.
  // Slot-2 is only considered when slot 1 requests nothing.
  always_comb begin
    redir_s     = 1'b0;
    redir_br_s  = 1'b0;
    redir_tgt_s = 32'h0000_0000;
    if (pcsrcd[1]) begin
      redir_s     = 1'b1;
      redir_tgt_s = align_word(signextd);
    end else if (pcsrcd[0]) begin
      redir_s     = 1'b1;
      redir_br_s  = 1'b1;
      redir_tgt_s = align_word(pcbranchd);
    end else if (pcsrcd2[1]) begin
      redir_s     = 1'b1;
      redir_tgt_s = align_word(signextd2);
    end else if (pcsrcd2[0]) begin
      redir_s     = 1'b1;
      redir_br_s  = 1'b1;
      redir_tgt_s = align_word(pcbranchd2);
    end else begin
      redir_s     = 1'b0;
    end
  end

  // Non-redirect next PC (predicted or sequential) and saturating counter step.
  always_comb begin
    seq_pc_s  = pcf_r + STRIDE_C;
    cnt_inc_s = redirect_cnt_r + 16'h0001;
    if (predict_taken) begin
      seq_pc_s = align_word(predict_target);
    end else begin
      seq_pc_s = pcf_r + STRIDE_C;
    end
    if (redirect_cnt_r == 16'hFFFF) begin
      cnt_inc_s = redirect_cnt_r;
    end else begin
      cnt_inc_s = redirect_cnt_r + 16'h0001;
    end
  end

  // Sequencer state machine with all PC/pending/counter state registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      pcf_r          <= RESET_PC;
      pending_r      <= 32'h0000_0000;
      pending_br_r   <= 1'b0;
      flush_br_r     <= 1'b0;
      redirect_cnt_r <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r    <= ST_RUN;
          flush_br_r <= 1'b0;
        end
        ST_RUN: begin
          if (redir_s) begin
            if (!stallf) begin
              pcf_r          <= redir_tgt_s;
              flush_br_r     <= redir_br_s;
              redirect_cnt_r <= cnt_inc_s;
              state_r        <= ST_FLUSH;
            end else begin
              pending_r    <= redir_tgt_s;
              pending_br_r <= redir_br_s;
              state_r      <= ST_HOLD;
            end
          end else if (!stallf) begin
            pcf_r <= seq_pc_s;
          end
        end
        ST_FLUSH: begin
          if (!stallf) begin
            pcf_r      <= seq_pc_s;
            flush_br_r <= 1'b0;
            state_r    <= ST_RUN;
          end
        end
        ST_HOLD: begin
          if (!stallf) begin
            pcf_r          <= pending_r;
            flush_br_r     <= pending_br_r;
            redirect_cnt_r <= cnt_inc_s;
            state_r        <= ST_FLUSH;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          pcf_r      <= RESET_PC;
          flush_br_r <= 1'b0;
        end
      endcase
    end
  end

  assign pcf          = pcf_r;
  assign redirect_cnt = redirect_cnt_r;
  assign state        = state_r;
  assign fetch_valid  = (state_r == ST_RUN) || (state_r == ST_FLUSH);
  assign flushd       = (state_r == ST_FLUSH);
  assign clrbp        = (state_r == ST_FLUSH) && flush_br_r;

endmodule
